// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat ledger: bet/result side encoding and the
// settlement sequencer state.
package baccarat_pkg;

    typedef logic [1:0] side_t;

    localparam side_t SIDE_NONE   = 2'b00;
    localparam side_t SIDE_PLAYER = 2'b01;
    localparam side_t SIDE_DEALER = 2'b10;
    localparam side_t SIDE_TIE    = 2'b11;

    typedef enum logic [1:0] {
        OPEN   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } ledger_state_t;

endpackage

// File: rtl/baccarat_payout.sv
// Combinational settlement of one player: (balance, wager, side, result) ->
// new balance. Wins saturate at 2^BAL_W-1, losses floor at 0.
// Optional: BACCARAT_COMMISSION_EN takes a 5% (floor) commission on winning
// dealer bets; without it dealer wins pay 1:1 and no divider is built.
module baccarat_payout
    import baccarat_pkg::*;
#(
    parameter int BAL_W    = 8,
    parameter int TIE_MULT = 8
) (
    input  logic [BAL_W-1:0] bal,
    input  logic [BAL_W-1:0] wager,
    input  logic [1:0]       side,
    input  logic [1:0]       result,
    output logic [BAL_W-1:0] new_bal
);

    // Wide enough for the largest tie payout on a full balance.
    localparam int ADD_W = BAL_W + $clog2(TIE_MULT) + 1;

    function automatic logic [BAL_W-1:0] sat_add(input logic [ADD_W-1:0] a,
                                                 input logic [ADD_W-1:0] b);
        logic [ADD_W-1:0] sum;
        logic [ADD_W-1:0] top;
        sum = a + b;
        top = {{(ADD_W-BAL_W){1'b0}}, {BAL_W{1'b1}}};
        return (sum > top) ? top[BAL_W-1:0] : sum[BAL_W-1:0];
    endfunction

    function automatic logic [BAL_W-1:0] floor_sub(input logic [BAL_W-1:0] a,
                                                   input logic [BAL_W-1:0] b);
        return (b > a) ? '0 : a - b;
    endfunction

    logic [ADD_W-1:0] bal_x;
    logic [ADD_W-1:0] wager_x;
    logic [ADD_W-1:0] gain;

    // Pick the winning gain for this result, then apply win/push/loss.
    always_comb begin
        bal_x   = ADD_W'(bal);
        wager_x = ADD_W'(wager);
        gain    = wager_x;
        if (result == SIDE_TIE) begin
            gain = wager_x * ADD_W'(TIE_MULT);
        end
`ifdef BACCARAT_COMMISSION_EN
        else if (result == SIDE_DEALER) begin
            gain = wager_x - (wager_x / ADD_W'(20));
        end
`endif
        if (side == SIDE_NONE) begin
            new_bal = bal;
        end else if (side == result) begin
            new_bal = sat_add(bal_x, gain);
        end else if (result == SIDE_TIE) begin
            new_bal = bal;
        end else begin
            new_bal = floor_sub(bal, wager);
        end
    end

endmodule

// File: rtl/baccarat_ledger.sv
// Multi-player baccarat wager/balance ledger. Bets are taken while OPEN; a
// round result settles one player per clock through a single shared payout
// unit. Optional commission on dealer wins: BACCARAT_COMMISSION_EN.
module baccarat_ledger
    import baccarat_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int BAL_W       = 8,
    parameter int INIT_BAL    = 16,
    parameter int TIE_MULT    = 8,
    localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         resetb,
    input  logic                         bet_valid,
    input  logic [PW-1:0]                bet_player,
    input  logic [1:0]                   bet_side,
    input  logic [BAL_W-1:0]             bet_amt,
    output logic                         bet_accept,
    output logic                         bet_reject,
    input  logic                         result_valid,
    input  logic [1:0]                   result,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_PLAYERS*BAL_W-1:0] balances
);

    ledger_state_t    state, state_nxt;
    logic [PW-1:0]    idx;
    side_t            res_q;
    logic [BAL_W-1:0] bal_q  [NUM_PLAYERS];
    side_t            side_q [NUM_PLAYERS];
    logic [BAL_W-1:0] amt_q  [NUM_PLAYERS];

    logic [BAL_W-1:0] sel_bal;
    logic [BAL_W-1:0] cur_bal;
    logic [BAL_W-1:0] cur_amt;
    side_t            cur_side;
    logic [BAL_W-1:0] new_bal;
    logic             result_go;
    logic             bet_ok;

    assign result_go = result_valid && (result != SIDE_NONE);
    assign bet_ok    = (32'(bet_player) < 32'(NUM_PLAYERS)) && (bet_amt <= sel_bal)
                       && ((bet_side == SIDE_NONE) || (bet_amt != '0));

    // Select the betting player's balance and the ledger entry being settled.
    always_comb begin
        sel_bal  = '0;
        cur_bal  = '0;
        cur_amt  = '0;
        cur_side = SIDE_NONE;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bet_player == PW'(i)) sel_bal = bal_q[i];
            if (idx == PW'(i)) begin
                cur_bal  = bal_q[i];
                cur_amt  = amt_q[i];
                cur_side = side_q[i];
            end
        end
    end

    baccarat_payout #(
        .BAL_W    (BAL_W),
        .TIE_MULT (TIE_MULT)
    ) u_payout (
        .bal     (cur_bal),
        .wager   (cur_amt),
        .side    (cur_side),
        .result  (res_q),
        .new_bal (new_bal)
    );

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= OPEN;
        else         state <= state_nxt;
    end

    // Next-state logic: a non-empty result starts settlement, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            OPEN:    if (result_go) state_nxt = SETTLE;
            SETTLE:  if (idx == PW'(NUM_PLAYERS - 1)) state_nxt = DONE;
            DONE:    state_nxt = OPEN;
            default: state_nxt = OPEN;
        endcase
    end

    // Outputs: a concurrent result always wins over a bet.
    always_comb begin
        busy       = (state == SETTLE);
        done       = (state == DONE);
        bet_accept = (state == OPEN) && bet_valid && !result_go && bet_ok;
        bet_reject = bet_valid && !bet_accept;
    end

    // Settlement index and captured result.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            idx   <= '0;
            res_q <= SIDE_NONE;
        end else if (state == OPEN && result_go) begin
            idx   <= '0;
            res_q <= result;
        end else if (state == SETTLE) begin
            idx   <= idx + 1'b1;
        end
    end

    // Per-player ledger: record accepted bets, settle and clear one entry per cycle.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                bal_q[i]  <= BAL_W'(INIT_BAL);
                side_q[i] <= SIDE_NONE;
                amt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (bet_accept && bet_player == PW'(i)) begin
                    side_q[i] <= bet_side;
                    amt_q[i]  <= (bet_side == SIDE_NONE) ? '0 : bet_amt;
                end
                if (state == SETTLE && idx == PW'(i)) begin
                    bal_q[i]  <= new_bal;
                    side_q[i] <= SIDE_NONE;
                    amt_q[i]  <= '0;
                end
            end
        end
    end

    // Flatten balances onto the output bus.
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            balances[i*BAL_W +: BAL_W] = bal_q[i];
        end
    end

endmodule

// File: tb/tb_baccarat_ledger.sv
// Self-checking bench for baccarat_ledger: table vectors, hand sequences for
// settle/reset corners, and random rounds against a behavioural ledger model.
module tb_baccarat_ledger;

    localparam int N        = 4;
    localparam int BAL_W    = 8;
    localparam int INIT_BAL = 16;
    localparam int TIE_MULT = 8;
    localparam int MAXB     = (1 << BAL_W) - 1;

    logic             clk = 1'b0;
    logic             resetb = 1'b0;
    logic             bet_valid = 1'b0;
    logic [1:0]       bet_player = '0;
    logic [1:0]       bet_side = '0;
    logic [BAL_W-1:0] bet_amt = '0;
    logic             bet_accept, bet_reject;
    logic             result_valid = 1'b0;
    logic [1:0]       result = '0;
    logic             busy, done;
    logic [N*BAL_W-1:0] balances;

    logic             bv3 = 1'b0;
    logic [1:0]       bp3 = '0;
    logic             acc3, rej3, busy3, done3;
    logic [3*BAL_W-1:0] bal3;

    int total = 0;
    int bad = 0;

    int m_bal [N];
    int m_side[N];
    int m_amt [N];

    typedef struct {
        int p;
        int s;
        int a;
        int exp_acc;
    } bet_vec_t;

    always #5 clk = ~clk;

    baccarat_ledger #(.NUM_PLAYERS(N), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL), .TIE_MULT(TIE_MULT)) u_dut (
        .clk(clk), .resetb(resetb), .bet_valid(bet_valid), .bet_player(bet_player),
        .bet_side(bet_side), .bet_amt(bet_amt), .bet_accept(bet_accept), .bet_reject(bet_reject),
        .result_valid(result_valid), .result(result), .busy(busy), .done(done), .balances(balances)
    );

    // Three-player instance so an out-of-range player index is representable.
    baccarat_ledger #(.NUM_PLAYERS(3), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL), .TIE_MULT(TIE_MULT)) u_dut3 (
        .clk(clk), .resetb(resetb), .bet_valid(bv3), .bet_player(bp3),
        .bet_side(bet_side), .bet_amt(bet_amt), .bet_accept(acc3), .bet_reject(rej3),
        .result_valid(1'b0), .result(2'b00), .busy(busy3), .done(done3), .balances(bal3)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_bal(input int i);
        return int'(balances[i*BAL_W +: BAL_W]);
    endfunction

    function automatic int settle_model(input int b, input int w, input int s, input int r);
        int g;
        if (s == 0) return b;
        if (s == r) begin
            g = (r == 3) ? TIE_MULT * w : w;
`ifdef BACCARAT_COMMISSION_EN
            if (r == 2) g = w - w / 20;
`endif
            return (b + g > MAXB) ? MAXB : b + g;
        end
        if (r == 3) return b;
        return (w > b) ? 0 : b - w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_bal[i] = INIT_BAL; m_side[i] = 0; m_amt[i] = 0;
        end
    endtask

    task automatic model_settle(input int r);
        for (int i = 0; i < N; i++) begin
            m_bal[i] = settle_model(m_bal[i], m_amt[i], m_side[i], r);
            m_side[i] = 0; m_amt[i] = 0;
        end
    endtask

    task automatic check_all_bal(input string tag);
        for (int i = 0; i < N; i++) check($sformatf("%s_bal%0d", tag, i), dut_bal(i), m_bal[i]);
    endtask

    // Called at posedge+1; returns at posedge+1. exp_acc < 0 means use the model.
    task automatic place_bet(input int p, input int s, input int a, input int exp_acc);
        int e;
        e = (p < N && a <= m_bal[p] && (s == 0 || a != 0)) ? 1 : 0;
        if (exp_acc >= 0) check($sformatf("table_rule_p%0d", p), e, exp_acc);
        bet_valid = 1'b1; bet_player = 2'(p); bet_side = 2'(s); bet_amt = BAL_W'(a);
        @(negedge clk);
        check($sformatf("bet_accept_p%0d_s%0d_a%0d", p, s, a), int'(bet_accept), e);
        check($sformatf("bet_reject_p%0d_s%0d_a%0d", p, s, a), int'(bet_reject), 1 - e);
        @(posedge clk); #1;
        bet_valid = 1'b0;
        if (e == 1) begin
            m_side[p] = s;
            m_amt[p] = (s == 0) ? 0 : a;
        end
    endtask

    // Present a result for one cycle and watch the settlement window.
    task automatic run_round(input int r);
        int nbusy, ndone, done_at;
        result_valid = 1'b1; result = 2'(r);
        @(posedge clk); #1;
        result_valid = 1'b0;
        nbusy = 0; ndone = 0; done_at = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
        end
        @(posedge clk); #1;
        check($sformatf("busy_cycles_r%0d", r), nbusy, (r == 0) ? 0 : N);
        check($sformatf("done_pulses_r%0d", r), ndone, (r == 0) ? 0 : 1);
        if (r != 0) begin
            check("done_latency", done_at, N + 1);
            model_settle(r);
        end
        check_all_bal($sformatf("round_r%0d", r));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bet_vec_t vecs[6];
        int nd;
        vecs[0] = '{p: 0, s: 1, a: 5,  exp_acc: 1};
        vecs[1] = '{p: 1, s: 2, a: 3,  exp_acc: 1};
        vecs[2] = '{p: 2, s: 1, a: 17, exp_acc: 0};
        vecs[3] = '{p: 3, s: 2, a: 0,  exp_acc: 0};
        vecs[4] = '{p: 3, s: 1, a: 7,  exp_acc: 1};
        vecs[5] = '{p: 3, s: 0, a: 9,  exp_acc: 1};

        model_reset();
        repeat (3) @(posedge clk);
        #1 resetb = 1'b1;
        @(posedge clk); #1;

        // Reset state
        for (int i = 0; i < N; i++) check($sformatf("reset_bal%0d", i), dut_bal(i), INIT_BAL);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // Out-of-range player on the three-player instance, then an in-range one.
        bv3 = 1'b1; bp3 = 2'd3; bet_side = 2'd1; bet_amt = 8'd4;
        @(negedge clk);
        check("oor_reject", int'(rej3), 1);
        check("oor_accept", int'(acc3), 0);
        @(posedge clk); #1;
        bp3 = 2'd2;
        @(negedge clk);
        check("inrange_accept", int'(acc3), 1);
        @(posedge clk); #1;
        bv3 = 1'b0;

        // Table-driven bets, last bet on P3 is withdrawn by side 00.
        for (int v = 0; v < 6; v++) place_bet(vecs[v].p, vecs[v].s, vecs[v].a, vecs[v].exp_acc);
        run_round(1);
        check("r1_p0_const", dut_bal(0), 21);
        check("r1_p1_const", dut_bal(1), 13);
        check("r1_p3_const", dut_bal(3), 16);

        // Empty round: stored bets must already be cleared.
        run_round(2);
        run_round(0);

        // Tie and saturation; player/dealer bets push on a tie.
        place_bet(2, 3, 16, 1);
        place_bet(0, 1, 4, 1);
        place_bet(1, 2, 2, 1);
        run_round(3);
        check("tie_p2_const", dut_bal(2), 144);
        place_bet(2, 3, 20, 1);
        run_round(3);
        check("tie_sat_const", dut_bal(2), 255);

        // Dealer losses then a dealer win of 40.
        place_bet(2, 2, 40, 1);
        run_round(1);
        place_bet(2, 2, 40, 1);
        run_round(1);
        place_bet(2, 2, 40, 1);
        run_round(2);
`ifdef BACCARAT_COMMISSION_EN
        check("dealer_win_const", dut_bal(2), 175 + 38);
`else
        check("dealer_win_const", dut_bal(2), 175 + 40);
`endif

        // Bet during SETTLE is refused and leaves the stored bet intact.
        place_bet(3, 1, 2, 1);
        result_valid = 1'b1; result = 2'd1;
        @(posedge clk); #1;
        result_valid = 1'b0;
        bet_valid = 1'b1; bet_player = 2'd3; bet_side = 2'd2; bet_amt = 8'd1;
        @(negedge clk);
        check("settle_bet_reject", int'(bet_reject), 1);
        check("settle_bet_accept", int'(bet_accept), 0);
        @(posedge clk); #1;
        bet_valid = 1'b0;
        nd = 0;
        for (int k = 0; k < 10 && nd == 0; k++) begin
            @(negedge clk);
            if (done) nd = 1;
        end
        @(posedge clk); #1;
        check("settle_done_seen", nd, 1);
        model_settle(1);
        check_all_bal("settle_bet");

        // Randomized rounds against the model.
        for (int it = 0; it < 25; it++) begin
            for (int b = 0; b < 3; b++) begin
                int p;
                p = int'($urandom_range(0, N - 1));
                place_bet(p, int'($urandom_range(0, 3)), int'($urandom_range(0, m_bal[p] + 2)), -1);
            end
            run_round(int'($urandom_range(0, 3)));
        end

        // Simultaneous bet and result, then reset during the second SETTLE cycle.
        place_bet(0, 1, 3, -1);
        bet_valid = 1'b1; bet_player = 2'd1; bet_side = 2'd1; bet_amt = 8'd1;
        result_valid = 1'b1; result = 2'd2;
        @(negedge clk);
        check("simul_reject", int'(bet_reject), 1);
        check("simul_accept", int'(bet_accept), 0);
        @(posedge clk); #1;
        bet_valid = 1'b0; result_valid = 1'b0;
        @(posedge clk); #2;
        resetb = 1'b0;
        #1;
        model_reset();
        check_all_bal("midreset");
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        @(posedge clk); @(posedge clk); #1;
        resetb = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        @(posedge clk); #1;
        check("post_reset_idle", nd, 0);
        run_round(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
